motor_ramp_ctrl: RTL and testbench
==================================

MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 Parameter RAMP_DIV, default 1000: clk cycles per ramp step (legal range >= 2).
REQ-002 Parameter DEAD_TICKS, default 8: number of ramp ticks spent in dead time on a direction reversal (legal range >= 1).
REQ-003 Port clk, input, 1 bit: single system clock; all state is updated on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port estop, input, 1 bit: emergency stop, level-sensitive, sampled on clk.
REQ-006 Port cmd_valid, input, 1 bit: a command is offered on cmd_ch/cmd_lo.
REQ-007 Port cmd_ready, output, 1 bit: the block can accept a command this cycle.
REQ-008 Port cmd_ch, input, 2 bits: target channel, 0..3.
REQ-009 Port cmd_lo, input, 8 bits: bit 7 is the target direction; bits 6:0 are the target duty, 0..127.
REQ-010 Port pwm_lo, output, 32 bits: per-channel PWM command; channel n occupies bits 8n+7:8n and is {dir, duty[6:0]}.
REQ-011 Port pwm_en, output, 4 bits: per-channel PWM enable.
REQ-012 Port pwm_cl, output, 4 bits: per-channel PWM clear.
REQ-013 Port busy, output, 4 bits: per channel, 1 while the channel is not IDLE.

Function
REQ-014 A shared prescaler shall count 0..RAMP_DIV-1 and wrap; the tick pulse is 1 for exactly one cycle when count == RAMP_DIV-1.
REQ-015 cmd_ready shall equal ~estop; a command is accepted on a cycle with cmd_valid & cmd_ready; the channel's target register (tgt_dir, tgt_duty) updates on that edge, and there is no command queue.
REQ-016 Each channel shall hold cur_dir, cur_duty (7 bits) and a state in {IDLE, RAMP, DEAD}.
REQ-017 IDLE -> RAMP on the cycle after a command is accepted for the channel; otherwise IDLE is held.
REQ-018 RAMP, reversal case (tgt_duty != 0 and tgt_dir != cur_dir), evaluated on each tick: if cur_duty > 0, cur_duty decrements by 1; else enter DEAD with the dead counter at 0.
REQ-019 RAMP, normal case, evaluated on each tick: cur_duty steps by exactly 1 toward tgt_duty; if cur_duty already equals tgt_duty, enter IDLE. The duty never skips values and never wraps (it saturates at 0 and 127).
REQ-020 A target with tgt_duty == 0 shall not change cur_dir; the channel ramps to 0 and goes IDLE.
REQ-021 DEAD: the dead counter increments once per tick; on the tick where it reaches DEAD_TICKS, cur_dir <= tgt_dir and the state returns to RAMP.
REQ-022 A command received during RAMP or DEAD shall retarget the channel only, with no restart; it is evaluated at the next tick under REQ-018 to REQ-021.
REQ-023 A command and a tick on the same channel in the same cycle: that tick uses the old target; the new target applies from the next tick.
REQ-024 Outputs shall be registered and equal to current state: pwm_lo[n] = {cur_dir, cur_duty}; pwm_en[n] = 0 in DEAD, else 1; pwm_cl[n] = 1 in DEAD, else 0.
REQ-025 Estop asserted: on the next edge every channel gets cur_duty = 0, tgt_duty = 0, state IDLE (cur_dir and tgt_dir unchanged); pwm_en = 0000, pwm_cl = 1111, prescaler held at 0, and no command is accepted.
REQ-026 Estop deasserted: normal operation resumes from all channels IDLE at duty 0; targets are not restored.
REQ-027 Channels shall operate independently; a command on one channel shall not alter any other channel's timing or state.

Reset
REQ-028 Asserting rst_n low shall, immediately and without a clock edge, force: prescaler 0; all cur/tgt duty and dir 0; all states IDLE; pwm_lo = 0; pwm_en = 0000; pwm_cl = 1111; busy = 0000.
REQ-029 On the first edge after rst_n deasserts with estop = 0: pwm_en = 1111, pwm_cl = 0000, cmd_ready = 1.

Verification (RAMP_DIV = 4, DEAD_TICKS = 2)
REQ-030 Reset, then ch0 command 0x05: pwm_lo[7:0] steps 1,2,3,4,5 on consecutive ticks, 4 cycles apart; busy[0] falls on the tick after duty reaches 5.
REQ-031 Ch1 at 0x03 (IDLE), then command 0x83: duty 2,1,0 on successive ticks; pwm_en[1] = 0 and pwm_cl[1] = 1 for 2 ticks; then dir = 1 and duty 1,2,3; pwm_lo[15:8] ends at 0x83.
REQ-032 Ch2 ramping toward 100, retargeted with 0x04 when at 10: duty 9,8,...,4 one per tick, then IDLE, with no dead time.
REQ-033 Estop mid-ramp on all 4 channels: next edge pwm_lo = 0, pwm_cl = 1111, cmd_ready = 0; after release all channels stay at duty 0 and IDLE.
REQ-034 Commands to ch0..ch3 on 4 consecutive cycles: all accepted, and each channel ramps independently to its own target.
REQ-035 rst_n pulsed low asynchronously while ch1 is in DEAD: outputs take the REQ-028 values before the next clk edge.

Source files
------------

// File: rtl/motor_ramp_ctrl.sv
// Four-channel motor PWM ramp controller: per-channel duty ramping at one step per
// prescaler tick, with a dead-time pause on direction reversal and a level estop.
module motor_ramp_ctrl #(
    parameter int RAMP_DIV   = 1000,
    parameter int DEAD_TICKS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        estop,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_ch,
    input  logic [7:0]  cmd_lo,
    output logic [31:0] pwm_lo,
    output logic [3:0]  pwm_en,
    output logic [3:0]  pwm_cl,
    output logic [3:0]  busy
);

    localparam int PW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DEAD = 2'd2
    } ch_state_e;

    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_s;
    logic          tick_s;
    logic          accept_s;

    ch_state_e     state_r    [4];
    ch_state_e     state_s    [4];
    logic          cur_dir_r  [4];
    logic          cur_dir_s  [4];
    logic [6:0]    cur_duty_r [4];
    logic [6:0]    cur_duty_s [4];
    logic          tgt_dir_r  [4];
    logic          tgt_dir_s  [4];
    logic [6:0]    tgt_duty_r [4];
    logic [6:0]    tgt_duty_s [4];
    logic [DW-1:0] dead_cnt_r [4];
    logic [DW-1:0] dead_cnt_s [4];
    logic [3:0]    pwm_en_r;
    logic [3:0]    pwm_en_s;
    logic [3:0]    pwm_cl_r;
    logic [3:0]    pwm_cl_s;

    assign tick_s    = (presc_r == PW'(RAMP_DIV - 1));
    assign cmd_ready = ~estop;
    assign accept_s  = cmd_valid & ~estop;
    assign pwm_en    = pwm_en_r;
    assign pwm_cl    = pwm_cl_r;

    for (genvar n = 0; n < 4; n++) begin : g_out
        assign pwm_lo[8*n +: 8] = {cur_dir_r[n], cur_duty_r[n]};
        assign busy[n]          = (state_r[n] != ST_IDLE);
    end

    // Shared prescaler: free-running ramp tick source, parked at zero during estop.
    always_comb begin
        presc_s = presc_r;
        if (estop) begin
            presc_s = '0;
        end else if (tick_s) begin
            presc_s = '0;
        end else begin
            presc_s = presc_r + PW'(1);
        end
    end

    // Per-channel next state: targets, ramp stepping, dead time and registered PWM gating.
    always_comb begin
        pwm_en_s = pwm_en_r;
        pwm_cl_s = pwm_cl_r;
        for (int ch = 0; ch < 4; ch++) begin
            state_s[ch]    = state_r[ch];
            cur_dir_s[ch]  = cur_dir_r[ch];
            cur_duty_s[ch] = cur_duty_r[ch];
            tgt_dir_s[ch]  = tgt_dir_r[ch];
            tgt_duty_s[ch] = tgt_duty_r[ch];
            dead_cnt_s[ch] = dead_cnt_r[ch];

            if (estop) begin
                // Directions are deliberately kept so a resume starts from a known polarity.
                state_s[ch]    = ST_IDLE;
                cur_duty_s[ch] = 7'd0;
                tgt_duty_s[ch] = 7'd0;
                dead_cnt_s[ch] = '0;
            end else begin
                case (state_r[ch])
                    ST_IDLE: begin
                        if (accept_s && (cmd_ch == 2'(ch))) begin
                            state_s[ch] = ST_RAMP;
                        end else begin
                            state_s[ch] = ST_IDLE;
                        end
                    end
                    ST_RAMP: begin
                        if (!tick_s) begin
                            state_s[ch] = ST_RAMP;
                        end else if ((tgt_duty_r[ch] != 7'd0) && (tgt_dir_r[ch] != cur_dir_r[ch])) begin
                            if (cur_duty_r[ch] != 7'd0) begin
                                cur_duty_s[ch] = cur_duty_r[ch] - 7'd1;
                            end else begin
                                state_s[ch]    = ST_DEAD;
                                dead_cnt_s[ch] = '0;
                            end
                        end else if (cur_duty_r[ch] < tgt_duty_r[ch]) begin
                            cur_duty_s[ch] = cur_duty_r[ch] + 7'd1;
                        end else if (cur_duty_r[ch] > tgt_duty_r[ch]) begin
                            cur_duty_s[ch] = cur_duty_r[ch] - 7'd1;
                        end else begin
                            state_s[ch] = ST_IDLE;
                        end
                    end
                    ST_DEAD: begin
                        if (!tick_s) begin
                            state_s[ch] = ST_DEAD;
                        end else if (dead_cnt_r[ch] == DW'(DEAD_TICKS - 1)) begin
                            cur_dir_s[ch]  = tgt_dir_r[ch];
                            state_s[ch]    = ST_RAMP;
                            dead_cnt_s[ch] = '0;
                        end else begin
                            dead_cnt_s[ch] = dead_cnt_r[ch] + DW'(1);
                        end
                    end
                    default: begin
                        state_s[ch] = ST_IDLE;
                    end
                endcase

                // Target only moves here; the tick above has already used the old one.
                if (accept_s && (cmd_ch == 2'(ch))) begin
                    tgt_dir_s[ch]  = cmd_lo[7];
                    tgt_duty_s[ch] = cmd_lo[6:0];
                end else begin
                    tgt_dir_s[ch]  = tgt_dir_r[ch];
                    tgt_duty_s[ch] = tgt_duty_r[ch];
                end
            end

            if (estop) begin
                pwm_en_s[ch] = 1'b0;
                pwm_cl_s[ch] = 1'b1;
            end else begin
                pwm_en_s[ch] = (state_s[ch] != ST_DEAD);
                pwm_cl_s[ch] = (state_s[ch] == ST_DEAD);
            end
        end
    end

    // State and output registers with asynchronous reset to the safe PWM-off state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r  <= '0;
            pwm_en_r <= 4'b0000;
            pwm_cl_r <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                state_r[i]    <= ST_IDLE;
                cur_dir_r[i]  <= 1'b0;
                cur_duty_r[i] <= 7'd0;
                tgt_dir_r[i]  <= 1'b0;
                tgt_duty_r[i] <= 7'd0;
                dead_cnt_r[i] <= '0;
            end
        end else begin
            presc_r  <= presc_s;
            pwm_en_r <= pwm_en_s;
            pwm_cl_r <= pwm_cl_s;
            for (int i = 0; i < 4; i++) begin
                state_r[i]    <= state_s[i];
                cur_dir_r[i]  <= cur_dir_s[i];
                cur_duty_r[i] <= cur_duty_s[i];
                tgt_dir_r[i]  <= tgt_dir_s[i];
                tgt_duty_r[i] <= tgt_duty_s[i];
                dead_cnt_r[i] <= dead_cnt_s[i];
            end
        end
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Scoreboard bench for motor_ramp_ctrl: expected output snapshots (with cycle gaps)
// are queued by the stimulus and popped by a monitor on every output change.
module tb_motor_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        estop;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ch;
    logic [7:0]  cmd_lo;
    logic [31:0] pwm_lo;
    logic [3:0]  pwm_en;
    logic [3:0]  pwm_cl;
    logic [3:0]  busy;

    typedef struct {
        logic [44:0] snap;
        int          gap;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          last_cyc = 0;
    int          n_pop    = 0;
    logic [44:0] last_snap = 'x;

    motor_ramp_ctrl #(.RAMP_DIV(4), .DEAD_TICKS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .estop     (estop),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ch    (cmd_ch),
        .cmd_lo    (cmd_lo),
        .pwm_lo    (pwm_lo),
        .pwm_en    (pwm_en),
        .pwm_cl    (pwm_cl),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Monitor: every visible output change must match the next queued snapshot.
    always @(negedge clk) begin
        logic [44:0] cur;
        exp_t        e;
        cyc++;
        cur = {cmd_ready, pwm_lo, pwm_en, pwm_cl, busy};
        if (cur !== last_snap) begin
            n_checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_change: actual=%h required=no change", cur);
            end else begin
                e = q.pop_front();
                n_pop++;
                if (cur === e.snap) begin
                    n_pass++;
                end else begin
                    $display("FAIL snapshot#%0d: actual=%h required=%h", n_pop, cur, e.snap);
                end
                if (e.gap != 0) begin
                    n_checks++;
                    if ((cyc - last_cyc) == e.gap) begin
                        n_pass++;
                    end else begin
                        $display("FAIL gap#%0d: actual=%0d required=%0d cycles", n_pop, cyc - last_cyc, e.gap);
                    end
                end
            end
            last_snap = cur;
            last_cyc  = cyc;
        end
    end

    task automatic put(input logic rdy, input logic [31:0] lo, input logic [3:0] en,
                       input logic [3:0] bsy, input int gap);
        exp_t e;
        e.snap = {rdy, lo, en, ~en, bsy};
        e.gap  = gap;
        q.push_back(e);
    endtask

    task automatic send(input logic [1:0] ch, input logic [7:0] lo);
        cmd_valid = 1'b1;
        cmd_ch    = ch;
        cmd_lo    = lo;
        @(negedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((q.size() != 0) && (n < max_cyc)) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain_timeout: actual=%0d pending required=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        estop     = 1'b0;
        cmd_valid = 1'b0;
        cmd_ch    = 2'd0;
        cmd_lo    = 8'h00;
        put(1'b1, 32'h0, 4'h0, 4'h0, 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        put(1'b1, 32'h0, 4'hF, 4'h0, 0);
        drain(20);

        // ch0 ramps 1..5 one step per tick, goes idle a tick later
        put(1'b1, 32'h0, 4'hF, 4'h1, 1);
        put(1'b1, 32'h01, 4'hF, 4'h1, 0);
        for (int k = 2; k <= 5; k++) put(1'b1, 32'(k), 4'hF, 4'h1, 4);
        put(1'b1, 32'h05, 4'hF, 4'h0, 4);
        send(2'd0, 8'h05);
        drain(60);

        // four back-to-back commands, last one accepted on a tick edge
        put(1'b1, 32'h0000_0005, 4'hF, 4'h1, 1);
        put(1'b1, 32'h0000_0005, 4'hF, 4'h3, 1);
        put(1'b1, 32'h0000_0005, 4'hF, 4'h7, 1);
        put(1'b1, 32'h0001_0106, 4'hF, 4'hF, 1);
        put(1'b1, 32'h0102_0207, 4'hF, 4'hF, 4);
        put(1'b1, 32'h0203_0308, 4'hF, 4'hF, 4);
        put(1'b1, 32'h0304_0408, 4'hF, 4'hE, 4);
        put(1'b1, 32'h0305_0508, 4'hF, 4'h6, 4);
        put(1'b1, 32'h0306_0608, 4'hF, 4'h6, 4);
        put(1'b1, 32'h0307_0608, 4'hF, 4'h4, 4);
        put(1'b1, 32'h0307_0608, 4'hF, 4'h0, 4);
        send(2'd0, 8'h08);
        send(2'd1, 8'h06);
        send(2'd2, 8'h07);
        send(2'd3, 8'h03);
        drain(80);

        // all channels ramping, then estop; a command offered during estop is refused
        put(1'b1, 32'h0307_0608, 4'hF, 4'h1, 1);
        put(1'b1, 32'h0307_0608, 4'hF, 4'h3, 1);
        put(1'b1, 32'h0307_0608, 4'hF, 4'h7, 1);
        put(1'b1, 32'h0308_0709, 4'hF, 4'hF, 1);
        put(1'b1, 32'h0409_080A, 4'hF, 4'hF, 4);
        send(2'd0, 8'h20);
        send(2'd1, 8'h20);
        send(2'd2, 8'h20);
        send(2'd3, 8'h20);
        drain(40);
        put(1'b0, 32'h0, 4'h0, 4'h0, 1);
        estop     = 1'b1;
        cmd_valid = 1'b1;
        cmd_ch    = 2'd2;
        cmd_lo    = 8'h10;
        repeat (4) @(negedge clk);
        #1;
        cmd_valid = 1'b0;
        put(1'b1, 32'h0, 4'hF, 4'h0, 0);
        estop = 1'b0;
        drain(20);
        repeat (16) @(negedge clk);
        #1;

        // ch1 to 0x03, then reversal to 0x83 through two dead ticks
        put(1'b1, 32'h0, 4'hF, 4'h2, 0);
        put(1'b1, 32'h0000_0100, 4'hF, 4'h2, 0);
        put(1'b1, 32'h0000_0200, 4'hF, 4'h2, 4);
        put(1'b1, 32'h0000_0300, 4'hF, 4'h2, 4);
        put(1'b1, 32'h0000_0300, 4'hF, 4'h0, 4);
        send(2'd1, 8'h03);
        drain(60);
        put(1'b1, 32'h0000_0300, 4'hF, 4'h2, 1);
        put(1'b1, 32'h0000_0200, 4'hF, 4'h2, 3);
        put(1'b1, 32'h0000_0100, 4'hF, 4'h2, 4);
        put(1'b1, 32'h0000_0000, 4'hF, 4'h2, 4);
        put(1'b1, 32'h0000_0000, 4'hD, 4'h2, 4);
        put(1'b1, 32'h0000_8000, 4'hF, 4'h2, 8);
        put(1'b1, 32'h0000_8100, 4'hF, 4'h2, 4);
        put(1'b1, 32'h0000_8200, 4'hF, 4'h2, 4);
        put(1'b1, 32'h0000_8300, 4'hF, 4'h2, 4);
        put(1'b1, 32'h0000_8300, 4'hF, 4'h0, 4);
        send(2'd1, 8'h83);
        drain(80);

        // ch2 toward 100, retargeted to 4 at duty 10: straight ramp down, no dead time
        put(1'b1, 32'h0000_8300, 4'hF, 4'h4, 1);
        for (int k = 1; k <= 10; k++) put(1'b1, {8'h00, 8'(k), 16'h8300}, 4'hF, 4'h4, (k == 1) ? 3 : 4);
        send(2'd2, 8'h64);
        drain(80);
        for (int k = 9; k >= 4; k--) put(1'b1, {8'h00, 8'(k), 16'h8300}, 4'hF, 4'h4, 4);
        put(1'b1, 32'h0004_8300, 4'hF, 4'h0, 4);
        send(2'd2, 8'h04);
        drain(60);

        // ch1 reversal into dead time, then asynchronous reset mid-cycle
        put(1'b1, 32'h0004_8300, 4'hF, 4'h2, 1);
        put(1'b1, 32'h0004_8200, 4'hF, 4'h2, 3);
        put(1'b1, 32'h0004_8100, 4'hF, 4'h2, 4);
        put(1'b1, 32'h0004_8000, 4'hF, 4'h2, 4);
        put(1'b1, 32'h0004_8000, 4'hD, 4'h2, 4);
        send(2'd1, 8'h05);
        drain(60);
        put(1'b1, 32'h0, 4'h0, 4'h0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pwm_lo, pwm_en, pwm_cl, busy} === {32'h0, 4'h0, 4'hF, 4'h0}) begin
            n_pass++;
        end else begin
            $display("FAIL async_reset: actual=%h required=%h",
                     {pwm_lo, pwm_en, pwm_cl, busy}, {32'h0, 4'h0, 4'hF, 4'h0});
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        put(1'b1, 32'h0, 4'hF, 4'h0, 0);
        drain(20);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
